// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencing controller:
// FSM state encoding, opcodes, ALU codes and datapath mux encodings.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWRITE,
    S_MEMWB,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_TRAP
  } mc_state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // States whose exit to FETCH completes an instruction
  function automatic logic is_retire_state(input mc_state_t s);
    return (s == S_MEMWB) || (s == S_ALUWB) || (s == S_BRANCH) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU operation decoder: the FSM picks add, sub or a funct-field decode.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alucontrol
);

  // Map ALUOp plus instruction funct fields onto an ALU control code
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore sequencing controller for the multi-cycle RV32I core: steps each
// instruction through its states, stalls on mem_ready, counts retirements.
module multicycle_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic             RegWrite,
  output logic [2:0]       ALUControl,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  mc_state_t   state;
  mc_state_t   next_state;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  aluop;
  logic        pcwrite_raw;
  logic        memwrite_raw;
  logic        irwrite_raw;
  logic        regwrite_raw;
  logic        retire;
  logic        unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  // Enables are held off for the whole reset pulse, not just until the next edge
  assign PCWrite  = pcwrite_raw  & rst_n;
  assign MemWrite = memwrite_raw & rst_n;
  assign IRWrite  = irwrite_raw  & rst_n;
  assign RegWrite = regwrite_raw & rst_n;
  assign illegal  = (state == S_TRAP);

  assign retire = is_retire_state(state) && (next_state == S_FETCH);

  mc_alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct3     (funct3),
    .funct7b5   (instr[30]),
    .op5        (instr[5]),
    .alucontrol (ALUControl)
  );

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  // Retired-instruction counter, wraps naturally at its width
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retired <= '0;
    else if (retire) retired <= retired + CNT_W'(1);
  end

  // Next-state logic; opcode is only trusted from DECODE onward
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:    if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXECUTER;
          OP_IALU:      next_state = S_EXECUTEI;
          OP_BRANCH:    next_state = (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
          OP_JAL:       next_state = S_JAL;
          default:      next_state = S_TRAP;
        endcase
      end
      S_MEMADR:   next_state = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) next_state = S_MEMWB;
      S_MEMWRITE: if (mem_ready) next_state = S_FETCH;
      S_EXECUTER, S_EXECUTEI, S_JAL:   next_state = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH:      next_state = S_FETCH;
      S_TRAP:     next_state = S_TRAP;
      default:    next_state = S_FETCH;
    endcase
  end

  // Moore output decode for the datapath muxes and raw enables
  always_comb begin
    pcwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    AdrSrc       = 1'b0;
    ResultSrc    = RES_ALUOUT;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_RD2;
    ImmSrc       = IMM_I;
    aluop        = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        ALUSrcB     = SRCB_FOUR;
        ResultSrc   = RES_ALURESULT;
        irwrite_raw = mem_ready;
        pcwrite_raw = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_B;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (opcode == OP_SW) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc       = 1'b1;
        memwrite_raw = mem_ready;
      end
      S_MEMWB: begin
        ResultSrc    = RES_DATA;
        regwrite_raw = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RD1;
        aluop   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regwrite_raw = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = SRCA_RD1;
        aluop       = ALUOP_SUB;
        pcwrite_raw = zero ^ funct3[0];
      end
      S_JAL: begin
        ALUSrcA     = SRCA_OLDPC;
        ALUSrcB     = SRCB_FOUR;
        ImmSrc      = IMM_J;
        pcwrite_raw = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm.
module tb_multicycle_control_fsm;
  import mc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic [31:0] retired;
  logic [16:0] obs;

  int vectors = 0;
  int miscompares = 0;
  int exp_ret = 0;

  multicycle_control_fsm #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .RegWrite(RegWrite), .ALUControl(ALUControl), .illegal(illegal), .retired(retired)
  );

  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ImmSrc, RegWrite, ALUControl, illegal};

  always #5 clk = ~clk;

  // Reference outputs per state; mask marks which fields are defined there
  task automatic model(input mc_state_t s, input logic [31:0] ins, input logic z,
                       input logic mr, input logic [2:0] ealu,
                       output logic [16:0] v, output logic [16:0] m);
    v = '0;
    m = '0;
    m[16] = 1'b1; m[14] = 1'b1; m[13] = 1'b1; m[4] = 1'b1; m[0] = 1'b1;
    case (s)
      S_FETCH: begin
        m[15] = 1'b1; m[12:7] = '1; m[3:1] = '1;
        v[12:11] = 2'b10; v[8:7] = 2'b10; v[16] = mr; v[13] = mr;
      end
      S_DECODE: begin
        m[10:5] = '1; m[3:1] = '1;
        v[10:9] = 2'b01; v[8:7] = 2'b01; v[6:5] = 2'b10;
      end
      S_MEMADR: begin
        m[10:5] = '1; m[3:1] = '1;
        v[10:9] = 2'b10; v[8:7] = 2'b01;
        v[6:5] = (ins[6:0] == 7'b0100011) ? 2'b01 : 2'b00;
      end
      S_MEMREAD: begin
        m[15] = 1'b1; m[12:11] = '1; v[15] = 1'b1;
      end
      S_MEMWRITE: begin
        m[15] = 1'b1; m[12:11] = '1; v[15] = 1'b1; v[14] = mr;
      end
      S_MEMWB: begin
        m[12:11] = '1; v[12:11] = 2'b01; v[4] = 1'b1;
      end
      S_EXECUTER: begin
        m[10:7] = '1; m[3:1] = '1; v[10:9] = 2'b10; v[3:1] = ealu;
      end
      S_EXECUTEI: begin
        m[10:5] = '1; m[3:1] = '1; v[10:9] = 2'b10; v[8:7] = 2'b01; v[3:1] = ealu;
      end
      S_ALUWB: begin
        m[12:11] = '1; v[4] = 1'b1;
      end
      S_BRANCH: begin
        m[12:7] = '1; m[3:1] = '1; v[10:9] = 2'b10; v[3:1] = 3'b001;
        v[16] = z ^ ins[12];
      end
      S_JAL: begin
        m[12:5] = '1; m[3:1] = '1;
        v[10:9] = 2'b01; v[8:7] = 2'b10; v[6:5] = 2'b11; v[16] = 1'b1;
      end
      S_TRAP: v[0] = 1'b1;
      default: ;
    endcase
  endtask

  // Asynchronous reset: enables forced low, FETCH selects, counter cleared
  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; instr = '0; zero = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({PCWrite, MemWrite, IRWrite, RegWrite, illegal} !== 5'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_enables%0d: got %b want 00000", k,
                 {PCWrite, MemWrite, IRWrite, RegWrite, illegal});
      end
      vectors++;
      if ({AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl} !== 10'b0_10_00_10_000) begin
        miscompares++;
        $display("[TB] FAIL reset_selects%0d: got %b want 0100010000", k,
                 {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl});
      end
      vectors++;
      if (retired !== 32'd0) begin
        miscompares++;
        $display("[TB] FAIL reset_retired: got %0d want 0", retired);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    exp_ret = 0;
  endtask

  // sw stalled in MEMWRITE, then reset mid-wait abandons it
  task automatic test_store_reset();
    mc_state_t   seq[5] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE, S_MEMWRITE};
    logic        mr[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [16:0] ev, em;
    instr = 32'h00102223;
    for (int i = 0; i < 5; i++) begin
      mem_ready = mr[i]; #1;
      model(seq[i], instr, zero, mem_ready, 3'b000, ev, em);
      vectors++;
      if ((obs & em) !== (ev & em)) begin
        miscompares++;
        $display("[TB] FAIL sw_wait cyc%0d: got %b want %b mask %b", i, obs, ev, em);
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({MemWrite, AdrSrc, ResultSrc, ALUSrcB} !== 6'b0_0_10_10) begin
      miscompares++;
      $display("[TB] FAIL sw_reset_state: got %b want 001010", {MemWrite, AdrSrc, ResultSrc, ALUSrcB});
    end
    vectors++;
    if (retired !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL sw_reset_retired: got %0d want 0", retired);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_ret = 0;
  endtask

  // lw with memory always ready: five states, write-back only in the last
  task automatic test_lw();
    mc_state_t   seq[5] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB};
    logic [16:0] ev, em;
    instr = 32'h00402083;
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'b1; #1;
      model(seq[i], instr, zero, mem_ready, 3'b000, ev, em);
      vectors++;
      if ((obs & em) !== (ev & em)) begin
        miscompares++;
        $display("[TB] FAIL lw cyc%0d: got %b want %b mask %b", i, obs, ev, em);
      end
      @(posedge clk); #1;
    end
    exp_ret++;
    vectors++;
    if (retired !== 32'(exp_ret) || IRWrite !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL lw_retire: got ret=%0d ir=%b want ret=%0d ir=1", retired, IRWrite, exp_ret);
    end
  endtask

  // sw that waits one cycle for memory, then strobes MemWrite once
  task automatic test_store();
    mc_state_t   seq[5] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE, S_MEMWRITE};
    logic        mr[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [16:0] ev, em;
    instr = 32'h00102223;
    for (int i = 0; i < 5; i++) begin
      mem_ready = mr[i]; #1;
      model(seq[i], instr, zero, mem_ready, 3'b000, ev, em);
      vectors++;
      if ((obs & em) !== (ev & em)) begin
        miscompares++;
        $display("[TB] FAIL sw cyc%0d: got %b want %b mask %b", i, obs, ev, em);
      end
      @(posedge clk); #1;
    end
    exp_ret++;
    vectors++;
    if (retired !== 32'(exp_ret)) begin
      miscompares++;
      $display("[TB] FAIL sw_retire: got %0d want %0d", retired, exp_ret);
    end
  endtask

  // FETCH stalled three cycles; IR/PC load exactly once, then addi flows on
  task automatic test_fetch_stall();
    mc_state_t   seq[7] = '{S_FETCH, S_FETCH, S_FETCH, S_FETCH, S_DECODE, S_EXECUTEI, S_ALUWB};
    logic        mr[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [16:0] ev, em;
    int          pulses = 0;
    int          pulse_cyc = -1;
    instr = 32'h40000093;
    for (int i = 0; i < 7; i++) begin
      mem_ready = mr[i]; #1;
      model(seq[i], instr, zero, mem_ready, 3'b000, ev, em);
      vectors++;
      if ((obs & em) !== (ev & em)) begin
        miscompares++;
        $display("[TB] FAIL stall_addi cyc%0d: got %b want %b mask %b", i, obs, ev, em);
      end
      if (IRWrite === 1'b1 && PCWrite === 1'b1) begin
        pulses++;
        pulse_cyc = i;
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (pulses != 1 || pulse_cyc != 3) begin
      miscompares++;
      $display("[TB] FAIL stall_pulse: got %0d pulses at cyc %0d want 1 at cyc 3", pulses, pulse_cyc);
    end
    exp_ret++;
    vectors++;
    if (retired !== 32'(exp_ret)) begin
      miscompares++;
      $display("[TB] FAIL stall_retire: got %0d want %0d", retired, exp_ret);
    end
  endtask

  // Back-to-back R-type ops covering each ALU decode case
  task automatic test_back_to_back();
    logic [31:0] ins[6]  = '{32'h40000033, 32'h00000033, 32'h00006033,
                             32'h00002033, 32'h00007033, 32'h00001033};
    logic [2:0]  alu[6]  = '{3'b001, 3'b000, 3'b011, 3'b101, 3'b010, 3'b000};
    mc_state_t   seq[4]  = '{S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB};
    logic [16:0] ev, em;
    for (int n = 0; n < 6; n++) begin
      instr = ins[n];
      for (int i = 0; i < 4; i++) begin
        mem_ready = 1'b1; #1;
        model(seq[i], instr, zero, mem_ready, alu[n], ev, em);
        vectors++;
        if ((obs & em) !== (ev & em)) begin
          miscompares++;
          $display("[TB] FAIL rtype%0d cyc%0d: got %b want %b mask %b", n, i, obs, ev, em);
        end
        @(posedge clk); #1;
      end
      exp_ret++;
    end
    vectors++;
    if (retired !== 32'(exp_ret)) begin
      miscompares++;
      $display("[TB] FAIL rtype_retire: got %0d want %0d", retired, exp_ret);
    end
  endtask

  // beq/bne resolve in three cycles; PCWrite follows zero and funct3[0]
  task automatic test_branch();
    logic [31:0] ins[3] = '{32'h00000063, 32'h00001063, 32'h00000063};
    logic        zz[3]  = '{1'b1, 1'b1, 1'b0};
    logic        pcw[3] = '{1'b1, 1'b0, 1'b0};
    mc_state_t   seq[3] = '{S_FETCH, S_DECODE, S_BRANCH};
    logic [16:0] ev, em;
    for (int n = 0; n < 3; n++) begin
      instr = ins[n]; zero = zz[n];
      for (int i = 0; i < 3; i++) begin
        mem_ready = 1'b1; #1;
        model(seq[i], instr, zero, mem_ready, 3'b000, ev, em);
        vectors++;
        if ((obs & em) !== (ev & em)) begin
          miscompares++;
          $display("[TB] FAIL branch%0d cyc%0d: got %b want %b mask %b", n, i, obs, ev, em);
        end
        if (i == 2) begin
          vectors++;
          if (PCWrite !== pcw[n]) begin
            miscompares++;
            $display("[TB] FAIL branch%0d_pcwrite: got %b want %b", n, PCWrite, pcw[n]);
          end
        end
        @(posedge clk); #1;
      end
      exp_ret++;
    end
    zero = 1'b0;
    vectors++;
    if (retired !== 32'(exp_ret)) begin
      miscompares++;
      $display("[TB] FAIL branch_retire: got %0d want %0d", retired, exp_ret);
    end
  endtask

  // jal: link via OldPC+4, PC loaded in the JAL state
  task automatic test_jal();
    mc_state_t   seq[4] = '{S_FETCH, S_DECODE, S_JAL, S_ALUWB};
    logic [16:0] ev, em;
    instr = 32'h0000006F;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; #1;
      model(seq[i], instr, zero, mem_ready, 3'b000, ev, em);
      vectors++;
      if ((obs & em) !== (ev & em)) begin
        miscompares++;
        $display("[TB] FAIL jal cyc%0d: got %b want %b mask %b", i, obs, ev, em);
      end
      @(posedge clk); #1;
    end
    exp_ret++;
    vectors++;
    if (retired !== 32'(exp_ret)) begin
      miscompares++;
      $display("[TB] FAIL jal_retire: got %0d want %0d", retired, exp_ret);
    end
  endtask

  // Unsupported encodings trap and stay trapped until reset
  task automatic test_trap();
    logic [31:0] ins[2] = '{32'h00000000, 32'h00002063};
    int          hold[2] = '{10, 2};
    logic [16:0] ev, em;
    for (int n = 0; n < 2; n++) begin
      instr = ins[n];
      for (int i = 0; i < 2 + hold[n]; i++) begin
        mem_ready = 1'b1; #1;
        model((i == 0) ? S_FETCH : (i == 1) ? S_DECODE : S_TRAP, instr, zero, mem_ready,
              3'b000, ev, em);
        vectors++;
        if ((obs & em) !== (ev & em)) begin
          miscompares++;
          $display("[TB] FAIL trap%0d cyc%0d: got %b want %b mask %b", n, i, obs, ev, em);
        end
        @(posedge clk); #1;
      end
      vectors++;
      if (retired !== 32'(exp_ret)) begin
        miscompares++;
        $display("[TB] FAIL trap%0d_retire: got %0d want %0d", n, retired, exp_ret);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({illegal, ALUSrcB, ResultSrc, IRWrite, PCWrite} !== 7'b0_10_10_0_0 || retired !== 32'd0) begin
        miscompares++;
        $display("[TB] FAIL trap%0d_reset: got %b ret=%0d want 0101000 ret=0", n,
                 {illegal, ALUSrcB, ResultSrc, IRWrite, PCWrite}, retired);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_ret = 0;
    end
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence
  initial begin
    test_reset();
    test_store_reset();
    test_lw();
    test_store();
    test_fetch_stall();
    test_back_to_back();
    test_branch();
    test_jal();
    test_trap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
